// File: rtl/red_pitaya_mux_demux.sv
// Receive side of the analog mux: averages each stable dwell of the shared ADC
// channel into a per-channel register and flags frames of refreshed channels.
module red_pitaya_mux_demux #(
    parameter int DWT      = 14,
    parameter int CHNL     = 6,
    parameter int AW       = 3,
    parameter int AVG_LOG2 = 4
) (
    input  logic                adc_clk_i,
    input  logic                adc_rstn_i,
    input  logic [DWT-1:0]      adc_a_i,
    input  logic [AW-1:0]       mux_addr_i,
    input  logic                signal_stable_i,
    input  logic [CHNL-1:0]     active_channels_i,
    input  logic                clr_i,
    output logic [CHNL*DWT-1:0] ch_data_o,
    output logic [CHNL-1:0]     ch_valid_o,
    output logic                sample_stb_o,
    output logic [AW-1:0]       sample_ch_o,
    output logic                frame_stb_o,
    output logic [15:0]         frame_cnt_o,
    output logic                short_window_o
);

    localparam int ACW = DWT + AVG_LOG2;
    localparam int CW  = AVG_LOG2 + 1;
    localparam int AL  = 2 ** AW;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [AW-1:0]         ch_q;
    logic signed [ACW-1:0] acc_q;
    logic [CW-1:0]         cnt_q;
    logic [DWT-1:0]        data_q [CHNL];
    logic [CHNL-1:0]       valid_q;
    logic                  sample_stb_q;
    logic [AW-1:0]         sample_ch_q;
    logic                  frame_stb_q;
    logic [15:0]           frame_cnt_q;
    logic                  short_q;

    logic [AL-1:0]         act_ext;
    logic                  in_range;
    logic                  hit;
    logic                  start;
    logic                  take;
    logic                  done;
    logic                  abort;
    logic [AW-1:0]         done_ch;
    logic signed [ACW-1:0] sample_ext;
    logic signed [ACW-1:0] sum;
    logic [CHNL-1:0]       oh;
    logic [CHNL-1:0]       v;
    logic                  frame_hit;

    assign act_ext    = AL'(active_channels_i);
    assign in_range   = 32'(mux_addr_i) < CHNL;
    assign hit        = signal_stable_i && (mux_addr_i == ch_q);
    assign sample_ext = ACW'(signed'(adc_a_i));

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        take    = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        done_ch = ch_q;
        sum     = acc_q + sample_ext;
        unique case (state_q)
            IDLE: begin
                if (signal_stable_i && in_range && act_ext[mux_addr_i]) begin
                    start   = 1'b1;
                    done_ch = mux_addr_i;
                    sum     = sample_ext;
                    if (AVG_LOG2 == 0) begin
                        done    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (hit) begin
                    take = 1'b1;
                    if (cnt_q == LAST) begin
                        done    = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr_i) begin
            state_d = IDLE;
            start   = 1'b0;
            take    = 1'b0;
            done    = 1'b0;
            abort   = 1'b0;
        end
    end

    // The bit of the completing channel joins the frame check in the same cycle.
    assign oh        = CHNL'(1) << done_ch;
    assign v         = valid_q | oh;
    assign frame_hit = (active_channels_i != '0) &&
                       ((v & active_channels_i) == active_channels_i);

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            ch_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            valid_q      <= '0;
            sample_stb_q <= 1'b0;
            sample_ch_q  <= '0;
            frame_stb_q  <= 1'b0;
            frame_cnt_q  <= '0;
            short_q      <= 1'b0;
            for (int k = 0; k < CHNL; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            sample_stb_q <= done;
            frame_stb_q  <= 1'b0;
            if (start) begin
                ch_q  <= mux_addr_i;
                acc_q <= sample_ext;
                cnt_q <= CW'(1);
            end else if (take) begin
                acc_q <= sum;
                cnt_q <= cnt_q + CW'(1);
            end
            if (done) begin
                // Slice of the sum is the floor shift truncated to DWT bits.
                data_q[done_ch] <= sum[AVG_LOG2 +: DWT];
                sample_ch_q     <= done_ch;
                if (frame_hit) begin
                    frame_stb_q <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + 16'd1;
                    valid_q     <= '0;
                end else begin
                    valid_q <= v;
                end
            end
            if (abort) begin
                short_q <= 1'b1;
            end
            if (clr_i) begin
                valid_q     <= '0;
                frame_cnt_q <= '0;
                short_q     <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < CHNL; k++) begin : g_data
        assign ch_data_o[k*DWT +: DWT] = data_q[k];
    end

    assign ch_valid_o     = valid_q;
    assign sample_stb_o   = sample_stb_q;
    assign sample_ch_o    = sample_ch_q;
    assign frame_stb_o    = frame_stb_q;
    assign frame_cnt_o    = frame_cnt_q;
    assign short_window_o = short_q;

endmodule

// File: tb/tb_red_pitaya_mux_demux.sv
// Scoreboard bench for red_pitaya_mux_demux with AVG_LOG2=4.
// Expected averages are hand-computed constants pushed at the Nth sample.
module tb_red_pitaya_mux_demux;

    localparam int DWT  = 14;
    localparam int CHNL = 6;
    localparam int AW   = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [DWT-1:0]      adc = '0;
    logic [AW-1:0]       addr = '0;
    logic                stable = 1'b0;
    logic [CHNL-1:0]     active = '0;
    logic                clr = 1'b0;
    logic [CHNL*DWT-1:0] ch_data;
    logic [CHNL-1:0]     ch_valid;
    logic                sample_stb;
    logic [AW-1:0]       sample_ch;
    logic                frame_stb;
    logic [15:0]         frame_cnt;
    logic                short_window;

    red_pitaya_mux_demux #(
        .DWT(DWT), .CHNL(CHNL), .AW(AW), .AVG_LOG2(4)
    ) dut (
        .adc_clk_i(clk),
        .adc_rstn_i(rst_n),
        .adc_a_i(adc),
        .mux_addr_i(addr),
        .signal_stable_i(stable),
        .active_channels_i(active),
        .clr_i(clr),
        .ch_data_o(ch_data),
        .ch_valid_o(ch_valid),
        .sample_stb_o(sample_stb),
        .sample_ch_o(sample_ch),
        .frame_stb_o(frame_stb),
        .frame_cnt_o(frame_cnt),
        .short_window_o(short_window)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [13:0] data;
        logic        fstb;
        logic [15:0] fcnt;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [13:0] slot(input int k);
        logic [CHNL*DWT-1:0] d;
        d = ch_data;
        return d[k*DWT +: DWT];
    endfunction

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && sample_stb) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_stb: ch %0d, no expectation queued",
                         sample_ch);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sample_ch", 32'(sample_ch), 32'(e.ch));
                chk("ch_data", 32'(slot(e.ch)), 32'(e.data));
                chk("frame_stb", 32'(frame_stb), 32'(e.fstb));
                chk("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
                chk("stb_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (rst_n && frame_stb) begin
            compared++;
            mismatched++;
            $display("FAIL frame_without_stb: frame_stb 1, sample_stb 0");
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            stable = 1'b0;
        end
    endtask

    // One stable dwell; samples alternate v0/v1. Pushes an expectation
    // for the 16th sample when exp_on is set.
    task automatic dwell(input int a, input int n, input int v0, input int v1,
                         input bit exp_on, input logic [13:0] ed,
                         input logic ef, input logic [15:0] ec);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            addr   = AW'(a);
            stable = 1'b1;
            adc    = DWT'((i % 2 == 0) ? v0 : v1);
            if (exp_on && i == 15) begin
                exp_t e;
                e.ch   = a;
                e.data = ed;
                e.fstb = ef;
                e.fcnt = ec;
                e.cyc  = cyc + 1;
                q.push_back(e);
            end
        end
        idle(3);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ch_data", 32'(ch_data != '0), 32'd0);
        chk("rst_valid", 32'(ch_valid), 32'd0);
        chk("rst_stb", 32'(sample_stb), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_short", 32'(short_window), 32'd0);
        rst_n = 1'b1;

        // Test 1: constant -100 on ch0
        active = 6'b000001;
        dwell(0, 20, -100, -100, 1, 14'h3F9C, 1'b1, 16'd1);

        // Test 2: floor rounding, sum -8
        dwell(0, 16, 0, -1, 1, 14'h3FFF, 1'b1, 16'd2);

        // Test 3: five channels, frame on ch4
        active = 6'b011111;
        dwell(0, 30, -100, -100, 1, 14'h3F9C, 1'b0, 16'd2);
        dwell(1, 30, -50, -50, 1, 14'h3FCE, 1'b0, 16'd2);
        dwell(2, 30, 0, 0, 1, 14'h0000, 1'b0, 16'd2);
        dwell(3, 30, 50, 50, 1, 14'h0032, 1'b0, 16'd2);
        chk("t3_valid_partial", 32'(ch_valid), 32'h0F);
        dwell(4, 30, 10, 10, 1, 14'h000A, 1'b1, 16'd3);
        chk("t3_valid_cleared", 32'(ch_valid), 32'h00);
        chk("t3_short", 32'(short_window), 32'd0);

        // Test 4: short dwell then clear
        dwell(0, 20, 7, 7, 1, 14'h0007, 1'b0, 16'd3);
        dwell(0, 10, 9, 9, 0, 14'h0, 1'b0, 16'd0);
        chk("t4_short_set", 32'(short_window), 32'd1);
        chk("t4_valid_kept", 32'(ch_valid), 32'h01);
        chk("t4_data_kept", 32'(slot(0)), 32'h0007);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("t4_short_clr", 32'(short_window), 32'd0);
        chk("t4_fcnt_clr", 32'(frame_cnt), 32'd0);
        chk("t4_valid_clr", 32'(ch_valid), 32'd0);
        chk("t4_data_after_clr", 32'(slot(0)), 32'h0007);

        // Test 5: sparse mask, inactive addresses ignored
        active = 6'b101001;
        dwell(0, 20, 20, 20, 1, 14'h0014, 1'b0, 16'd0);
        dwell(1, 20, 1, 1, 0, 14'h0, 1'b0, 16'd0);
        dwell(2, 20, 2, 2, 0, 14'h0, 1'b0, 16'd0);
        dwell(3, 20, -7, -7, 1, 14'h3FF9, 1'b0, 16'd0);
        chk("t5_valid_partial", 32'(ch_valid), 32'h09);
        dwell(4, 20, 4, 4, 0, 14'h0, 1'b0, 16'd0);
        dwell(5, 20, 1000, 1000, 1, 14'h03E8, 1'b1, 16'd1);
        chk("t5_valid_cleared", 32'(ch_valid), 32'h00);
        chk("t5_ch1_kept", 32'(slot(1)), 32'h3FCE);
        chk("t5_ch2_kept", 32'(slot(2)), 32'h0000);
        chk("t5_ch4_kept", 32'(slot(4)), 32'h000A);

        // Test 6: reset in the middle of an accumulation
        active = 6'b000001;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            addr   = '0;
            stable = 1'b1;
            adc    = DWT'(500);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        stable = 1'b0;
        #2;
        chk("t6_rst_data", 32'(ch_data != '0), 32'd0);
        chk("t6_rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("t6_rst_valid", 32'(ch_valid), 32'd0);
        chk("t6_rst_stb", 32'(sample_stb | frame_stb | short_window), 32'd0);
        idle(2);
        rst_n = 1'b1;
        dwell(0, 20, -3, -3, 1, 14'h3FFD, 1'b1, 16'd1);

        idle(4);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
